simd_result_collector: RTL and testbench
========================================

// Module: simd_result_collector
// PURPOSE
// - Sink end of the SIMD datapath: captures the four lane results (primary + extra word per lane)
//   and streams them to the memory controller as 128-bit beats over a valid/ready interface.
// - Mirror of the operand path (mc_data_in_opa/opb): buffers results, counts them against the
//   run length taken from data_size, and flags the end of the run.
// PARAMETERS
// - DEPTH   4   result FIFO entries (power of 2, >=2); each entry = 128b main + 128b extra + wide flag
// - LANE_W  32  bits per lane result
// - LANES   4   processor lanes; beat width = LANES*LANE_W = 128
// PORTS
// - clk        in   1    system clock
// - reset      in   1    asynchronous, active-high
// - start      in   1    1-cycle pulse; latches data_size and arms collection
// - data_size  in   6    number of results expected in the run (0..63)
// - res_valid  in   1    lane results valid this cycle
// - wide_op    in   1    1: emit extra beat after main beat for this result
// - res_main   in   128  lane i primary result at [32i+31:32i] (lane0 = out_procc0)
// - res_extra  in   128  lane i extra result, same packing (out_extra_procc*)
// - m_valid    out  1    output beat valid
// - m_ready    in   1    downstream accepts beat
// - m_data     out  128  output beat
// - m_last     out  1    beat is the final beat of the final result of the run
// - busy       out  1    run in progress
// - done       out  1    1-cycle pulse at end of run
// - overflow   out  1    sticky: a result was dropped (FIFO full); cleared by start
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; FIFO empty; counters 0.
// - FSM: IDLE -> RUN on start with data_size!=0 (busy=1, rx_cnt=0, tx_cnt=0, overflow cleared).
//   start with data_size==0: stay IDLE, done pulses the following cycle, no beats.
//   RUN -> IDLE on handshake (m_valid&m_ready) of the beat with m_last; done pulses the next cycle.
// - start while busy is ignored. res_valid in IDLE is ignored (not counted, not buffered).
// - Push: in RUN, res_valid with rx_cnt<expected writes {wide_op,res_extra,res_main}; rx_cnt++.
//   res_valid after rx_cnt==expected is ignored.
// - Full: push accepted if FIFO not full or a pop occurs the same cycle; otherwise the result is
//   dropped, overflow set, rx_cnt still increments (so the run still terminates).
// - Latency: result pushed into empty FIFO at edge N appears as m_valid at edge N (visible cycle N+1).
// - Beat sequencer per entry: MAIN beat (res_main) then, if wide, EXTRA beat (res_extra); entry
//   popped on handshake of its last beat. m_data/m_valid hold stable while m_valid&!m_ready.
// - m_last = 1 on the last beat of the entry whose result index == expected-1 (tx_cnt tracks
//   popped entries; dropped results have no beats, so if the final result was dropped m_last rides
//   the last surviving entry once rx_cnt==expected and FIFO holds exactly one entry).
// - If all results dropped/none remain once rx_cnt==expected and FIFO empty: RUN -> IDLE, done.
// - Counters 6-bit, no wrap possible (max 63). Reset mid-run: immediate return to reset state.
// STRUCTURE
// - simd_pkg: LANES, LANE_W, BEAT_W, beat-select enum {BEAT_MAIN, BEAT_EXTRA}, FSM state enum
//   {ST_IDLE, ST_RUN}.
// - Sub-module simd_result_fifo: synchronous FIFO, DEPTH x 257b, push/pop/full/empty, async reset.
// - Top: FSM, rx/tx counters, beat sequencer, overflow/done logic.
// TESTING
// - data_size=2, wide_op=0, res_main=128'h11111111_22222222_33333333_44444444 then
//   128'h12345678_87654321_01234567_76543210, m_ready=1 -> two beats equal to inputs, m_last on
//   second, done 1 cycle after it, busy falls.
// - data_size=1, wide_op=1, main=128'h55555555_22222222_44444444_44444444,
//   extra=128'h00000001_00000001_00000001_00000001 -> main beat then extra beat, m_last on extra only.
// - DEPTH=4, m_ready=0, data_size=5, 5 results -> overflow=1 after 5th, m_ready=1 -> exactly 4
//   beats, m_last on 4th, done pulses.
// - m_ready toggled every other cycle during data_size=3 run -> m_data/m_valid stable while stalled,
//   no beat duplicated or lost.
// - start with data_size=0 -> done next cycle, m_valid stays 0; start during RUN ignored (rx_cnt kept).
// - reset asserted with 2 entries buffered -> m_valid=0, busy=0, overflow=0 immediately; new run OK.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types for the SIMD result collector: lane geometry, beat select,
// FSM states and the buffered result entry layout.
package simd_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int BEAT_W = LANES * LANE_W;

    typedef enum logic {
        BEAT_MAIN  = 1'b0,
        BEAT_EXTRA = 1'b1
    } beat_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              wide;
        logic [BEAT_W-1:0] extra;
        logic [BEAT_W-1:0] main;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/simd_result_fifo.sv
// Purpose: synchronous FIFO holding buffered lane result entries.
// Latency: a push shows at the head the cycle after the write edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module simd_result_fifo #(
    parameter  int WIDTH = 257,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_MAX);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/simd_result_collector.sv
// Purpose: buffer SIMD lane results and stream them as 128-bit beats, flagging the run end.
// Latency: a result written into an empty FIFO drives m_valid the cycle after its write edge.
// Backpressure: m_data/m_valid hold while m_ready is low; results arriving on a full FIFO are dropped (overflow).
module simd_result_collector
    import simd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        data_size,
    input  logic              res_valid,
    input  logic              wide_op,
    input  logic [BEAT_W-1:0] res_main,
    input  logic [BEAT_W-1:0] res_extra,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE_ENTRY = CW'(1);
    localparam logic [5:0]    CNT_ONE   = 6'd1;

    state_e     state_q, state_d;
    beat_e      beat_q, beat_d;
    logic [5:0] expected_q, expected_d;
    logic [5:0] rx_cnt_q, rx_cnt_d;
    logic [5:0] tx_cnt_q, tx_cnt_d;
    logic       overflow_q, overflow_d;
    logic       done_q, done_d;

    entry_t        head, wr_entry;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          run, rx_done, last_beat, final_entry, hs, pop, push_req, push;

    simd_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (wr_entry),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        run       = (state_q == ST_RUN);
        rx_done   = (rx_cnt_q == expected_q);
        last_beat = (beat_q == BEAT_EXTRA) || !head.wide;
        // Final entry: either the run's last index, or the sole survivor once every result arrived.
        final_entry = (tx_cnt_q == expected_q - CNT_ONE) || (rx_done && (fifo_cnt == ONE_ENTRY));
        m_valid   = run && !fifo_empty;
        m_data    = (beat_q == BEAT_EXTRA) ? head.extra : head.main;
        m_last    = m_valid && last_beat && final_entry;
        hs        = m_valid && m_ready;
        pop       = hs && last_beat;
        push_req  = run && res_valid && !rx_done;
        push      = push_req && (!fifo_full || pop);
        wr_entry  = '{wide: wide_op, extra: res_extra, main: res_main};
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        expected_d = expected_q;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    overflow_d = 1'b0;
                    if (data_size == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        expected_d = data_size;
                        rx_cnt_d   = 6'd0;
                        tx_cnt_d   = 6'd0;
                        beat_d     = BEAT_MAIN;
                    end
                end
            end
            ST_RUN: begin
                if (push_req) begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                    if (!push) begin
                        overflow_d = 1'b1;
                    end
                end
                if (hs) begin
                    beat_d = last_beat ? BEAT_MAIN : BEAT_EXTRA;
                end
                if (pop) begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
                if ((hs && m_last) || (rx_done && fifo_empty)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_q     <= BEAT_MAIN;
            expected_q <= 6'd0;
            rx_cnt_q   <= 6'd0;
            tx_cnt_q   <= 6'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            expected_q <= expected_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_simd_result_collector.sv
// Directed bench for simd_result_collector: stimulus queues expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_simd_result_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   data_size;
    logic         res_valid;
    logic         wide_op;
    logic [127:0] res_main;
    logic [127:0] res_extra;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;
    logic         overflow;

    typedef struct packed {
        logic [127:0] dat;
        logic         last;
    } beat_t;

    beat_t sb[$];
    int    total    = 0;
    int    bad      = 0;
    int    done_cnt = 0;

    always #5 clk = ~clk;

    simd_result_collector #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_size (data_size),
        .res_valid (res_valid),
        .wide_op   (wide_op),
        .res_main  (res_main),
        .res_extra (res_extra),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] n);
        start     = 1'b1;
        data_size = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic w, input logic [127:0] mn, input logic [127:0] ex,
                        input logic ok, input logic lst);
        res_valid = 1'b1;
        wide_op   = w;
        res_main  = mn;
        res_extra = ex;
        if (ok) begin
            if (w) begin
                sb.push_back('{dat: mn, last: 1'b0});
                sb.push_back('{dat: ex, last: lst});
            end else begin
                sb.push_back('{dat: mn, last: lst});
            end
        end
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_busy_low"}, busy, 1'b0);
        chk({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: beat scoreboard, stall stability, done one cycle after the final beat.
    initial begin : monitor
        logic         stall_prev = 1'b0;
        logic [127:0] stall_dat  = '0;
        logic         done_due   = 1'b0;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
                done_due   = 1'b0;
            end else begin
                if (done_due) chk("done_after_last", done, 1'b1);
                done_due = 1'b0;
                if (done) done_cnt++;
                if (stall_prev) begin
                    chk("stall_valid", m_valid, 1'b1);
                    chk("stall_data", m_data, stall_dat);
                end
                stall_prev = m_valid && !m_ready;
                stall_dat  = m_data;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", m_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", m_data, e.dat);
                        chk("beat_last", m_last, e.last);
                        done_due = e.last;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        reset     = 1'b1;
        start     = 1'b0;
        data_size = 6'd0;
        res_valid = 1'b0;
        wide_op   = 1'b0;
        res_main  = '0;
        res_extra = '0;
        m_ready   = 1'b1;
        repeat (3) tick();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        reset = 1'b0;
        tick();

        // Two narrow results, always ready.
        do_start(6'd2);
        chk("t1_busy", busy, 1'b1);
        send(1'b0, 128'h11111111_22222222_33333333_44444444, '0, 1'b1, 1'b0);
        send(1'b0, 128'h12345678_87654321_01234567_76543210, '0, 1'b1, 1'b1);
        wait_idle("t1");

        // One wide result: main beat then extra beat, last only on extra.
        do_start(6'd1);
        send(1'b1, 128'h55555555_22222222_44444444_44444444,
             128'h00000001_00000001_00000001_00000001, 1'b1, 1'b1);
        wait_idle("t2");

        // Five results into a 4-deep FIFO with no drain: fifth dropped.
        m_ready = 1'b0;
        do_start(6'd5);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, {4{i[31:0] + 32'hA0}}, '0, i < 4, i == 3);
        end
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_valid_held", m_valid, 1'b1);
        chk("t3_not_last", m_last, 1'b0);
        m_ready = 1'b1;
        wait_idle("t3");
        chk("t3_overflow_sticky", overflow, 1'b1);

        // Toggling ready across a mixed narrow/wide run.
        do_start(6'd3);
        chk("t4_overflow_cleared", overflow, 1'b0);
        fork
            begin
                send(1'b0, 128'hC0C0C0C0_00000000_00000000_00000001, '0, 1'b1, 1'b0);
                send(1'b1, 128'hC1C1C1C1_00000000_00000000_00000002,
                     128'hE1E1E1E1_00000000_00000000_00000003, 1'b1, 1'b0);
                send(1'b0, 128'hC2C2C2C2_00000000_00000000_00000004, '0, 1'b1, 1'b1);
            end
            begin
                repeat (12) begin
                    tick();
                    m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        wait_idle("t4");
        chk("t4_no_overflow", overflow, 1'b0);

        // Zero-length run: done next cycle, no beats.
        do_start(6'd0);
        chk("t5_done", done, 1'b1);
        chk("t5_busy", busy, 1'b0);
        tick();
        chk("t5_done_pulse", done, 1'b0);
        chk("t5_no_valid", m_valid, 1'b0);

        // Start during a run is ignored: second result still ends a size-2 run.
        do_start(6'd2);
        send(1'b0, 128'hD0D0D0D0_11111111_22222222_33333333, '0, 1'b1, 1'b0);
        do_start(6'd5);
        send(1'b0, 128'hD1D1D1D1_44444444_55555555_66666666, '0, 1'b1, 1'b1);
        wait_idle("t6");

        // Reset with entries buffered and overflow set, then a fresh run.
        m_ready = 1'b0;
        do_start(6'd6);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, {4{i[31:0] + 32'hF0}}, '0, 1'b0, 1'b0);
        end
        chk("t7_pre_valid", m_valid, 1'b1);
        chk("t7_pre_overflow", overflow, 1'b1);
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", m_valid, 1'b0);
        chk("t7_rst_busy", busy, 1'b0);
        chk("t7_rst_overflow", overflow, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        m_ready = 1'b1;
        do_start(6'd1);
        send(1'b0, 128'hF00DF00D_12121212_34343434_56565656, '0, 1'b1, 1'b1);
        wait_idle("t7");
        tick();

        chk("done_count", done_cnt, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
